// File: rtl/vga_pkg.sv
// Shared types and default VGA 640x480 timing for the pixel output block.
package vga_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PRIME,
    RUN
  } fsm_t;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  function automatic int timing_total(input int active, input int fp,
                                      input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FP_DEF     = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BP_DEF     = 48;
  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF     = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BP_DEF     = 33;

  localparam int H_TOTAL_DEF = timing_total(H_ACTIVE_DEF, H_FP_DEF, H_SYNC_DEF, H_BP_DEF);
  localparam int V_TOTAL_DEF = timing_total(V_ACTIVE_DEF, V_FP_DEF, V_SYNC_DEF, V_BP_DEF);

endpackage

// File: rtl/vga_pixel_out_fifo.sv
// Synchronous pixel FIFO; push is ignored when full, pop ignored when empty.
module pixel_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 24
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];
  assign level   = count;

  // Storage array: data only, so it carries no reset.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointers and occupancy; a simultaneous push and pop leaves the count unchanged.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/vga_pixel_out.sv
// VGA pixel output: buffers pixels, generates raster timing on a pixel-clock
// enable and drives registered RGB/sync/blank to the display DAC.
module vga_pixel_out
  import vga_pkg::*;
#(
  parameter int H_ACTIVE   = H_ACTIVE_DEF,
  parameter int H_FP       = H_FP_DEF,
  parameter int H_SYNC     = H_SYNC_DEF,
  parameter int H_BP       = H_BP_DEF,
  parameter int V_ACTIVE   = V_ACTIVE_DEF,
  parameter int V_FP       = V_FP_DEF,
  parameter int V_SYNC     = V_SYNC_DEF,
  parameter int V_BP       = V_BP_DEF,
  parameter int PIX_DIV    = 2,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          enable,
  input  logic [23:0]                   pixel_in,
  input  logic                          pixel_valid,
  output logic                          pixel_ready,
  output logic                          hsync,
  output logic                          vsync,
  output logic                          blank_n,
  output logic [7:0]                    vga_r,
  output logic [7:0]                    vga_g,
  output logic [7:0]                    vga_b,
  output logic                          frame_start,
  output logic [15:0]                   underflow_cnt,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int H_TOTAL = timing_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = timing_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;
  localparam int DW = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_VIS  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_VIS  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [DW-1:0] DIV_LAST  = DW'(PIX_DIV - 1);
  localparam logic [LW-1:0] PRIME_LVL = LW'(FIFO_DEPTH / 2);

  function automatic logic [15:0] sat_inc16(input logic [15:0] val);
    return (val == 16'hFFFF) ? val : val + 16'd1;
  endfunction

  fsm_t            state_q;
  fsm_t            state_d;
  logic [DW-1:0]   div_p0;
  logic [HW-1:0]   h_p0;
  logic [VW-1:0]   v_p0;
  logic            tick;
  logic            h_wrap;
  logic            frame_wrap;
  logic            visible;
  logic            hs_act;
  logic            vs_act;
  logic            fifo_full;
  logic            fifo_empty;
  logic            pop;
  logic [23:0]     fifo_rd;
  rgb_t            fifo_pix;
  rgb_t            rgb_p1;
  logic            hsync_p1;
  logic            vsync_p1;
  logic            blank_p1;
  logic            fs_p1;
  logic [15:0]     uf_cnt;

  pixel_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (24)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (pixel_valid),
    .pop   (pop),
    .din   (pixel_in),
    .dout  (fifo_rd),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  assign fifo_pix    = rgb_t'(fifo_rd);
  assign pixel_ready = !fifo_full;

  // ---- stage p0: pixel tick, raster counters, region decode ----
  assign tick       = (state_q == RUN) && (div_p0 == DIV_LAST);
  assign h_wrap     = (h_p0 == H_LAST);
  assign frame_wrap = h_wrap && (v_p0 == V_LAST);
  assign visible    = (h_p0 < H_VIS) && (v_p0 < V_VIS);
  assign hs_act     = (h_p0 >= HS_BEG) && (h_p0 < HS_END);
  assign vs_act     = (v_p0 >= VS_BEG) && (v_p0 < VS_END);
  assign pop        = tick && visible;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next-state: prime the FIFO to half full before scanning; stop only at a frame boundary.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (enable) state_d = PRIME;
      PRIME: begin
        if (!enable)                       state_d = IDLE;
        else if (fifo_level >= PRIME_LVL)  state_d = RUN;
      end
      RUN:     if (tick && frame_wrap && !enable) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Pixel-clock divider, held at zero outside RUN so the first RUN tick lands on a fixed phase.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                  div_p0 <= '0;
    else if (state_q != RUN)   div_p0 <= '0;
    else if (div_p0 == DIV_LAST) div_p0 <= '0;
    else                       div_p0 <= div_p0 + 1'b1;
  end

  // Raster counters advance once per tick; parked at (0,0) outside RUN.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      h_p0 <= '0;
      v_p0 <= '0;
    end else if (state_q != RUN) begin
      h_p0 <= '0;
      v_p0 <= '0;
    end else if (tick) begin
      if (h_wrap) begin
        h_p0 <= '0;
        v_p0 <= (v_p0 == V_LAST) ? '0 : v_p0 + 1'b1;
      end else begin
        h_p0 <= h_p0 + 1'b1;
      end
    end
  end

  // ---- stage p1: registered display outputs, all delayed by the same tick ----
  // Output registers; colour comes from the FIFO head, black when blanked or starved.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rgb_p1   <= '0;
      hsync_p1 <= 1'b1;
      vsync_p1 <= 1'b1;
      blank_p1 <= 1'b0;
      fs_p1    <= 1'b0;
    end else if (state_q != RUN) begin
      rgb_p1   <= '0;
      hsync_p1 <= 1'b1;
      vsync_p1 <= 1'b1;
      blank_p1 <= 1'b0;
      fs_p1    <= 1'b0;
    end else if (tick) begin
      rgb_p1   <= (visible && !fifo_empty) ? fifo_pix : '0;
      hsync_p1 <= !hs_act;
      vsync_p1 <= !vs_act;
      blank_p1 <= visible;
      fs_p1    <= (h_p0 == '0) && (v_p0 == '0);
    end else begin
      fs_p1    <= 1'b0;
    end
  end

  // Underflow counter: one count per visible pixel shown while the FIFO was empty.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                             uf_cnt <= '0;
    else if (tick && visible && fifo_empty) uf_cnt <= sat_inc16(uf_cnt);
  end

  assign vga_r         = rgb_p1.r;
  assign vga_g         = rgb_p1.g;
  assign vga_b         = rgb_p1.b;
  assign hsync         = hsync_p1;
  assign vsync         = vsync_p1;
  assign blank_n       = blank_p1;
  assign frame_start   = fs_p1;
  assign underflow_cnt = uf_cnt;

endmodule

// File: tb/tb_vga_pixel_out.sv
// Directed bench for vga_pixel_out: small raster, PIX_DIV=1 and PIX_DIV=2 instances,
// pixel scoreboard plus sync width/position and frame_start checks.
module tb_vga_pixel_out;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // Instance A (PIX_DIV=1)
  logic        en_a = 1'b0, val_a = 1'b0;
  logic [23:0] pix_a = '0;
  logic        a_ready, a_hs, a_vs, a_blank, a_fs;
  logic [7:0]  a_r, a_g, a_b;
  logic [15:0] a_uf;
  logic [3:0]  a_lvl;

  // Instance B (PIX_DIV=2)
  logic        en_b = 1'b0, val_b = 1'b0;
  logic [23:0] pix_b = '0;
  logic        b_ready, b_hs, b_vs, b_blank, b_fs;
  logic [7:0]  b_r, b_g, b_b;
  logic [15:0] b_uf;
  logic [3:0]  b_lvl;

  vga_pixel_out #(.H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
                  .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1),
                  .PIX_DIV(1), .FIFO_DEPTH(8)) dut_a (
    .clk(clk), .rst(rst), .enable(en_a), .pixel_in(pix_a), .pixel_valid(val_a),
    .pixel_ready(a_ready), .hsync(a_hs), .vsync(a_vs), .blank_n(a_blank),
    .vga_r(a_r), .vga_g(a_g), .vga_b(a_b), .frame_start(a_fs),
    .underflow_cnt(a_uf), .fifo_level(a_lvl)
  );

  vga_pixel_out #(.H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
                  .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1),
                  .PIX_DIV(2), .FIFO_DEPTH(8)) dut_b (
    .clk(clk), .rst(rst), .enable(en_b), .pixel_in(pix_b), .pixel_valid(val_b),
    .pixel_ready(b_ready), .hsync(b_hs), .vsync(b_vs), .blank_n(b_blank),
    .vga_r(b_r), .vga_g(b_g), .vga_b(b_b), .frame_start(b_fs),
    .underflow_cnt(b_uf), .fifo_level(b_lvl)
  );

  // Monitor view of whichever instance is under test
  logic        sel = 1'b0;
  logic        m_hs, m_vs, m_blank, m_fs;
  logic [23:0] m_rgb;
  assign m_hs    = sel ? b_hs    : a_hs;
  assign m_vs    = sel ? b_vs    : a_vs;
  assign m_blank = sel ? b_blank : a_blank;
  assign m_fs    = sel ? b_fs    : a_fs;
  assign m_rgb   = sel ? {b_r, b_g, b_b} : {a_r, a_g, a_b};

  int          n_cmp = 0;
  int          n_err = 0;
  logic [23:0] exp_q[$];
  int          fs_cnt, vs_runs, hs_run, vs_run, hold, pos;
  bit          pos_ok;
  int          div, hs_len_exp, vs_len_exp, hs_pos_exp;
  logic        prev_hs, prev_vs, prev_blank;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic mon_reset(input int d);
    div        = d;
    hs_len_exp = 2 * d;
    vs_len_exp = 8 * d;
    hs_pos_exp = 5 * d;
    prev_hs = 1'b1; prev_vs = 1'b1; prev_blank = 1'b0;
    hs_run = 0; vs_run = 0; hold = 0; pos = 0; pos_ok = 0;
    fs_cnt = 0; vs_runs = 0;
  endtask

  // Compare one output sample against the scoreboard and sync expectations.
  task automatic monitor();
    if (m_blank === 1'b1) begin
      if (prev_blank !== 1'b1) begin
        pos = 0; pos_ok = 1; hold = 0;
      end
      if (exp_q.size() == 0) chk("rgb_underflow", m_rgb, 0);
      else begin
        chk("rgb_pixel", m_rgb, exp_q[0]);
        hold++;
        if (hold == div) begin
          void'(exp_q.pop_front());
          hold = 0;
        end
      end
    end else begin
      chk("rgb_blanked", m_rgb, 0);
      hold = 0;
    end
    if (prev_hs === 1'b1 && m_hs === 1'b0 && pos_ok) chk("hsync_pos", pos, hs_pos_exp);
    if (m_hs === 1'b0) hs_run++;
    else if (prev_hs === 1'b0) begin
      chk("hsync_width", hs_run, hs_len_exp);
      hs_run = 0;
      pos_ok = 0;
    end
    if (m_vs === 1'b0) vs_run++;
    else if (prev_vs === 1'b0) begin
      chk("vsync_width", vs_run, vs_len_exp);
      vs_run = 0;
      vs_runs++;
    end
    if (m_fs === 1'b1) fs_cnt++;
    if (pos_ok) pos++;
    prev_hs = m_hs; prev_vs = m_vs; prev_blank = m_blank;
  endtask

  // One clock: record any push the DUT will accept, then sample at the falling edge.
  task automatic step();
    if (!sel) begin
      if (val_a && a_ready) exp_q.push_back(pix_a);
    end else begin
      if (val_b && b_ready) exp_q.push_back(pix_b);
    end
    @(posedge clk);
    @(negedge clk);
    monitor();
  endtask

  task automatic wait_frame_start(input string tag);
    bit found = 0;
    for (int k = 0; k < 20 && !found; k++) begin
      step();
      if (fs_cnt > 0) found = 1;
    end
    chk(tag, found, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    mon_reset(1);
    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_ready", a_ready, 1);
    chk("rst_hsync", a_hs, 1);
    chk("rst_vsync", a_vs, 1);
    chk("rst_blank", a_blank, 0);
    chk("rst_rgb", {a_r, a_g, a_b}, 0);
    chk("rst_fs", a_fs, 0);
    chk("rst_uf", a_uf, 0);
    chk("rst_level", a_lvl, 0);
    rst = 1'b1;

    // Prime with four pixels, then scan one frame
    en_a = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      pix_a = 24'(i);
      val_a = 1'b1;
      step();
    end
    val_a = 1'b0;
    chk("prime_level", a_lvl, 4);
    chk("prime_blank", a_blank, 0);
    chk("prime_hsync", a_hs, 1);
    wait_frame_start("a_frame_start_seen");
    repeat (39) step();
    chk("a_underflow_frame1", a_uf, 4);
    chk("a_fs_count_frame1", fs_cnt, 1);
    chk("a_vsync_runs_frame1", vs_runs, 1);
    chk("a_queue_drained", exp_q.size(), 0);

    // Drop enable mid-frame: frame completes, then IDLE
    repeat (10) step();
    en_a = 1'b0;
    fs_cnt = 0;
    vs_runs = 0;
    repeat (60) step();
    chk("stop_fs_count", fs_cnt, 0);
    chk("stop_vsync_runs", vs_runs, 1);
    chk("stop_hsync", a_hs, 1);
    chk("stop_vsync", a_vs, 1);
    chk("stop_blank", a_blank, 0);
    chk("stop_underflow", a_uf, 12);

    // Fill to full in IDLE; extra pushes must be refused
    val_a = 1'b1;
    for (int k = 0; k < 10; k++) begin
      pix_a = 24'h10 + 24'(k);
      step();
    end
    chk("full_level", a_lvl, 8);
    chk("full_ready", a_ready, 0);

    // Run while streaming: first pop frees one slot, then push+pop keep level at 7
    en_a = 1'b1;
    for (int k = 0; k < 6; k++) begin
      pix_a = 24'h20 + 24'(k);
      step();
    end
    chk("pushpop_level", a_lvl, 7);
    chk("pushpop_ready", a_ready, 1);
    val_a = 1'b0;

    // Asynchronous reset mid-run
    rst = 1'b0;
    #1;
    chk("mid_rst_ready", a_ready, 1);
    chk("mid_rst_hsync", a_hs, 1);
    chk("mid_rst_vsync", a_vs, 1);
    chk("mid_rst_blank", a_blank, 0);
    chk("mid_rst_rgb", {a_r, a_g, a_b}, 0);
    chk("mid_rst_fs", a_fs, 0);
    chk("mid_rst_uf", a_uf, 0);
    chk("mid_rst_level", a_lvl, 0);
    exp_q.delete();
    en_a = 1'b0;
    @(negedge clk);
    rst = 1'b1;

    // PIX_DIV=2 instance: each pixel held two clocks, syncs twice as wide
    sel = 1'b1;
    mon_reset(2);
    en_b = 1'b1;
    for (int i = 0; i < 4; i++) begin
      pix_b = 24'hA1 + 24'(i);
      val_b = 1'b1;
      step();
    end
    val_b = 1'b0;
    wait_frame_start("b_frame_start_seen");
    repeat (79) step();
    chk("b_underflow_frame1", b_uf, 4);
    chk("b_fs_count", fs_cnt, 1);
    chk("b_vsync_runs", vs_runs, 1);
    chk("b_queue_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
